// File: rtl/ps2_host_ctrl.sv
`timescale 1ns/1ps
// ps2_host_ctrl
//   PS/2 host controller. It receives 11-bit device frames (start, d0..d7,
//   odd parity, stop) and transmits host command bytes with the usual
//   inhibit / request-to-send sequence, followed by the device acknowledge.
//   Both PS/2 lines are open-drain: the block only ever drives 0 or Z.
//
// Optional feature:
//   PS2_RX_WATCHDOG_EN - when defined, a watchdog aborts RX, TX or ACK if no
//   PS/2 clock falling edge is seen for TIMEOUT_CYCLES cycles. When it is
//   undefined, those states wait indefinitely.
//
// Ports:
//   CLOCK_50  in     system clock
//   Resetn    in     asynchronous active-low reset
//   PS2_CLK   inout  PS/2 clock (open-drain)
//   PS2_DAT   inout  PS/2 data (open-drain)
//   tx_data   in     command byte to send, latched on tx_valid && tx_ready
//   tx_valid  in     transmit request
//   tx_ready  out    high only in IDLE once out of reset
//   rx_data   out    last good received byte
//   rx_valid  out    one-cycle pulse: new rx_data
//   rx_err    out    one-cycle pulse: bad or aborted frame
//   tx_ack    out    one-cycle pulse: device acknowledged
//   tx_nack   out    one-cycle pulse: no acknowledge or aborted transmit
//   busy      out    FSM not in IDLE
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       tx_ack,
  output logic       tx_nack,
  output logic       busy
);

  // Parameter sanity checks at elaboration time.
  if (INHIBIT_CYCLES < 1) begin : g_bad_inhibit
    $error("INHIBIT_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic              clk_meta_q, clk_sync_q, clk_prev_q;
  logic              dat_meta_q, dat_sync_q;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        rx_shift_q, rx_shift_d;   // [0]=start, [8:1]=data, [9]=parity
  logic [7:0]        rx_data_q, rx_data_d;
  logic [9:0]        tx_shift_q, tx_shift_d;   // [7:0]=data, [8]=parity, [9]=stop
  logic              tx_bit_q, tx_bit_d;       // bit currently presented on PS2_DAT
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic              tx_ack_q, tx_ack_d;
  logic              tx_nack_q, tx_nack_d;
  logic              ready_q;
  logic              fall;
  logic              transfer;

`ifdef PS2_RX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
`endif

  assign fall     = clk_prev_q & ~clk_sync_q;
  assign tx_ready = ready_q && (state_q == S_IDLE);
  assign transfer = tx_valid && tx_ready;
  assign busy     = (state_q != S_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign tx_ack   = tx_ack_q;
  assign tx_nack  = tx_nack_q;

  // Line drivers decode straight from state so reset releases them at once.
  assign PS2_CLK = (state_q == S_INHIBIT) ? 1'b0 : 1'bz;
  assign PS2_DAT = ((state_q == S_REQ || state_q == S_TX) && !tx_bit_q) ? 1'b0 : 1'bz;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    inh_cnt_d  = inh_cnt_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_ack_d   = 1'b0;
    tx_nack_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A transmit request beats a simultaneous RX start edge.
        if (transfer) begin
          tx_shift_d = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d  = '0;
          state_d    = S_INHIBIT;
        end else if (fall && !dat_sync_q) begin
          rx_shift_d = '0;
          bit_cnt_d  = 4'd1;
          state_d    = S_RX;
        end
      end
      S_RX: begin
        if (fall) begin
          if (bit_cnt_q == 4'd10) begin
            // Stop bit is the live sample; parity covers d0..d7 and parity.
            if (!rx_shift_q[0] && dat_sync_q && (^rx_shift_q[9:1])) begin
              rx_data_d  = rx_shift_q[8:1];
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            rx_shift_d[bit_cnt_q] = dat_sync_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          tx_bit_d = 1'b0;               // start bit driven from REQ onwards
          state_d  = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      S_REQ: begin
        bit_cnt_d = '0;
        state_d   = S_TX;
      end
      S_TX: begin
        if (fall) begin
          tx_bit_d = tx_shift_q[bit_cnt_q];
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!dat_sync_q) tx_ack_d = 1'b1;
          else             tx_nack_d = 1'b1;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PS2_RX_WATCHDOG_EN
    // Cleared on every falling edge and whenever the state changes, so it
    // measures the idle time of the current RX/TX/ACK state.
    wd_cnt_d = '0;
    if ((state_q == S_RX || state_q == S_TX || state_q == S_ACK) &&
        (state_d == state_q) && !fall) begin
      if (wd_cnt_q == WD_LAST) begin
        if (state_q == S_RX) rx_err_d = 1'b1;
        else                 tx_nack_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      // Synchronizers start at the idle line level to avoid a false edge.
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= 8'h00;
      tx_shift_q <= '0;
      tx_bit_q   <= 1'b1;
      inh_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_ack_q   <= 1'b0;
      tx_nack_q  <= 1'b0;
      ready_q    <= 1'b0;
`ifdef PS2_RX_WATCHDOG_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      inh_cnt_q  <= inh_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_ack_q   <= tx_ack_d;
      tx_nack_q  <= tx_nack_d;
      ready_q    <= 1'b1;
`ifdef PS2_RX_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_host_ctrl;

  localparam int INH  = 5000;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, rx_err, tx_ack, tx_nack, busy;
  logic [7:0] rx_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk, ps2_dat;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  always #5 clk = ~clk;

  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_ack(tx_ack), .tx_nack(tx_nack), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts each pulse kind, overlapping pulses and pulses
  // wider than one cycle.
  int   cyc = 0;
  int   n_rxv = 0, n_rxe = 0, n_ack = 0, n_nack = 0, n_multi = 0, n_wide = 0;
  int   t_rxe = 0;
  logic p_rxv = 1'b0, p_rxe = 1'b0, p_ack = 1'b0, p_nack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) n_rxv <= n_rxv + 1;
    if (rx_err) begin
      n_rxe <= n_rxe + 1;
      t_rxe <= cyc;
    end
    if (tx_ack)  n_ack <= n_ack + 1;
    if (tx_nack) n_nack <= n_nack + 1;
    if (int'(rx_valid) + int'(rx_err) + int'(tx_ack) + int'(tx_nack) > 1) n_multi <= n_multi + 1;
    if ((rx_valid && p_rxv) || (rx_err && p_rxe) || (tx_ack && p_ack) || (tx_nack && p_nack))
      n_wide <= n_wide + 1;
    p_rxv  <= rx_valid;
    p_rxe  <= rx_err;
    p_ack  <= tx_ack;
    p_nack <= tx_nack;
  end

  int last_fall = 0;

  // Device drives one bit: data set while clock high, then one clock pulse.
  task automatic dev_bit(input logic b);
    @(negedge clk);
    dev_dat_low = !b;
    repeat (HALF/2) @(negedge clk);
    dev_clk_low = 1'b1;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF/2) @(negedge clk);
  endtask

  logic [7:0] exp_rx = 8'h00;

  // Device sends a frame; the model decides good/bad from the sent bits.
  task automatic dev_frame(input logic [7:0] d, input logic flip_par, input logic bad_stop);
    logic par, stop, good;
    int   v0, e0;
    v0 = n_rxv; e0 = n_rxe;
    par  = (($countones(d) % 2) == 0) ^ flip_par;
    stop = !bad_stop;
    good = ((($countones(d) + int'(par)) % 2) == 1) && stop;
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(d[i]);
    dev_bit(par);
    dev_bit(stop);
    dev_dat_low = 1'b0;
    repeat (HALF) @(negedge clk);
    if (good) exp_rx = d;
    chk("rx_valid_count", n_rxv - v0, good ? 1 : 0);
    chk("rx_err_count", n_rxe - e0, good ? 0 : 1);
    chk("rx_data", rx_data, exp_rx);
    chk("rx_busy_after", busy, 0);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk(tag, tx_ready, 1);
  endtask

  // Handshake, inhibit-length measurement and start-bit check.
  task automatic tx_start(input logic [7:0] d, input logic collide);
    int lo = 0;
    wait_ready("tx_ready_before");
    if (collide) begin
      dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      @(negedge clk);
      @(negedge clk);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    while (ps2_clk === 1'b0 && lo < INH + 100) begin
      lo++;
      @(negedge clk);
    end
    chk("inhibit_len", lo, INH);
    chk("start_bit", ps2_dat, 0);
  endtask

  task automatic dev_clock_read(output logic b);
    repeat (HALF/2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF/2) @(negedge clk);
    b = ps2_dat;
    repeat (HALF/2) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF/2) @(negedge clk);
  endtask

  task automatic tx_xfer(input logic [7:0] d, input logic ack, input logic collide);
    logic [9:0] got, exp;
    int a0, n0, e0;
    e0 = n_rxe;
    tx_start(d, collide);
    for (int i = 0; i < 10; i++) dev_clock_read(got[i]);
    exp = {1'b1, (($countones(d) % 2) == 0), d};
    chk("tx_bits", got, exp);
    a0 = n_ack; n0 = n_nack;
    repeat (HALF/2) @(negedge clk);
    dev_dat_low = ack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("tx_ack_count", n_ack - a0, ack ? 1 : 0);
    chk("tx_nack_count", n_nack - n0, ack ? 0 : 1);
    chk("tx_no_rx_err", n_rxe - e0, 0);
    wait_ready("tx_ready_after");
    chk("tx_busy_after", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic b;
    int a0, n0, e0, mode;

    // Reset state
    #23;
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {rx_valid, rx_err, tx_ack, tx_nack}, 4'b0000);
    chk("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tx_ready_after_reset", tx_ready, 1);

    // Fixed frames: bad parity first (rx_data must stay 0x00), then good.
    dev_frame(8'h1C, 1'b1, 1'b0);
    dev_frame(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      mode = $urandom_range(0, 3);
      dev_frame(d, mode == 0, mode == 1);
    end

    // Transmit: acknowledged, not acknowledged, random, and RX collision.
    tx_xfer(8'hED, 1'b1, 1'b0);
    tx_xfer(8'hED, 1'b0, 1'b0);
    tx_xfer(8'($urandom), 1'b1, 1'b0);
    tx_xfer(8'($urandom), 1'b1, 1'b1);

    // Device stops after five bits.
    e0 = n_rxe;
    dev_bit(1'b0);
    for (int i = 0; i < 4; i++) dev_bit(1'b1);
    dev_dat_low = 1'b0;
`ifdef PS2_RX_WATCHDOG_EN
    begin
      int w = 0;
      while (n_rxe == e0 && w < TMO + 200) begin
        @(negedge clk);
        w++;
      end
    end
    chk("wd_rx_err", n_rxe - e0, 1);
    chk("wd_latency", ((t_rxe - last_fall) >= TMO) && ((t_rxe - last_fall) <= TMO + 8), 1);
    chk("wd_busy", busy, 0);
`else
    repeat (TMO + 200) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_no_err", n_rxe - e0, 0);
`endif
    do_reset();
    chk("reset_recover_ready", tx_ready, 1);

    // Reset while the host presents d4 (0 for 0xED).
    tx_start(8'hED, 1'b0);
    for (int i = 0; i < 5; i++) dev_clock_read(b);
    chk("tx_d4_driven", ps2_dat, 0);
    a0 = n_ack; n0 = n_nack; e0 = n_rxe;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midtx_rst_lines", {ps2_clk, ps2_dat}, 2'b11);
    chk("midtx_rst_busy", busy, 0);
    chk("midtx_rst_ready", tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midtx_ready_after", tx_ready, 1);
    repeat (50) @(negedge clk);
    chk("midtx_no_pulse", (n_ack - a0) + (n_nack - n0) + (n_rxe - e0), 0);
    chk("midtx_rx_data", rx_data, 8'h00);

    chk("pulse_overlap", n_multi, 0);
    chk("pulse_width", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, the number of CLOCK_50 cycles PS2_CLK is held low before a host transmit (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the watchdog limit in CLOCK_50 cycles between PS/2 clock edges (2 ms).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: CLOCK_50  in  1  system clock; Resetn  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port PS2_CLK  inout  1  PS/2 clock, open-drain (drive 0 or Z only).
REQ-005 The block SHALL have port PS2_DAT  inout  1  PS/2 data, open-drain (drive 0 or Z only).
REQ-006 The block SHALL have port tx_data  in  8  command byte to send.
REQ-007 The block SHALL have port tx_valid  in  1  transmit request.
REQ-008 The block SHALL have port tx_ready  out  1  block accepts tx_data this cycle.
REQ-009 The block SHALL have port rx_data  out  8  last good received byte.
REQ-010 The block SHALL have port rx_valid  out  1  one-cycle pulse, new rx_data.
REQ-011 The block SHALL have port rx_err  out  1  one-cycle pulse, bad or aborted frame.
REQ-012 The block SHALL have port tx_ack  out  1  one-cycle pulse, device acknowledged.
REQ-013 The block SHALL have port tx_nack  out  1  one-cycle pulse, no acknowledge or aborted transmit.
REQ-014 The block SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL synchronize PS2_CLK and PS2_DAT through two flops each and SHALL define a falling edge as synchronized clock previous 1, current 0.
REQ-016 The FSM SHALL have states IDLE, RX, INHIBIT, REQ, TX, ACK and WAIT_IDLE.
REQ-017 tx_ready SHALL be 1 only in IDLE; a transfer occurs when tx_valid and tx_ready are both 1 in the same cycle, and tx_data is latched then.
REQ-018 In IDLE, a falling edge with synchronized data 0 SHALL move the FSM to RX, counting the start bit as bit 0.
REQ-019 In RX, data SHALL be sampled on each falling edge, LSB first, for 11 bits: start, d0..d7, parity, stop.
REQ-020 After bit 10, a frame with start=0, stop=1 and odd parity over d0..d7 plus parity SHALL update rx_data and pulse rx_valid one cycle after the edge-detect cycle.
REQ-021 A frame failing any of those checks SHALL pulse rx_err instead and leave rx_data unchanged; both cases SHALL then return to IDLE.
REQ-022 If a transfer and an RX start edge occur in the same IDLE cycle, TX SHALL win: the frame is discarded without rx_err.
REQ-023 INHIBIT SHALL drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-024 REQ SHALL release PS2_CLK and drive PS2_DAT low (start bit), then enter TX.
REQ-025 In TX, on each device falling edge the block SHALL present the next bit in order d0..d7, odd parity, then stop (released); after the stop bit it SHALL enter ACK.
REQ-026 ACK SHALL keep PS2_DAT released and sample it on the next falling edge: 0 pulses tx_ack, 1 pulses tx_nack; the FSM then enters WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL return to IDLE once synchronized clock and data are both 1.
REQ-028 rx_valid, rx_err, tx_ack and tx_nack SHALL each be at most one cycle wide, and at most one of them SHALL be asserted in any cycle.

Reset
REQ-029 Resetn low SHALL asynchronously force IDLE, release both PS/2 lines to Z, and clear rx_data to 0x00, all pulse outputs to 0, tx_ready to 0 and busy to 0.
REQ-030 tx_ready SHALL rise on the first CLOCK_50 edge after Resetn deasserts.
REQ-031 Reset mid-frame SHALL abandon the frame with no pulse output.

Configuration
REQ-032 With PS2_RX_WATCHDOG_EN defined, a counter SHALL clear on every falling edge and on state entry in RX, TX and ACK.
REQ-033 With PS2_RX_WATCHDOG_EN defined, reaching TIMEOUT_CYCLES SHALL abort: RX pulses rx_err, TX or ACK pulses tx_nack, lines are released, and the FSM enters IDLE.
REQ-034 With PS2_RX_WATCHDOG_EN undefined, no counter SHALL exist and the RX, TX and ACK states SHALL wait indefinitely.

Verification
REQ-035 Device frame 0x1C, parity 0, stop 1 -> rx_valid one pulse, rx_data=0x1C, no rx_err.
REQ-036 Device frame 0x1C, parity 1 -> rx_err one pulse, rx_data holds its previous value (0x00 after reset).
REQ-037 tx_data=0xED with tx_valid -> PS2_CLK low 5000 cycles, then bits 1,0,1,1,0,1,1,1, parity 1, stop; device pulls data 0 at ACK -> tx_ack pulse, then IDLE and tx_ready=1.
REQ-038 Same transmit with the device leaving data high at ACK -> tx_nack pulse.
REQ-039 With PS2_RX_WATCHDOG_EN defined, device stops after 5 bits -> rx_err pulse 100000 cycles after the last edge, busy=0; without the macro, busy stays 1.
REQ-040 Resetn pulsed low during TX bit 4 -> both lines Z immediately, no tx_ack or tx_nack, tx_ready=1 one cycle after release.
